// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: issues loads/stores on a req/gnt/rvalid bus,
// lane-aligns store data, extends load data and emits one result beat to MEM/WB.
module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int R_ADRESS_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic [DATA_WIDTH-1:0]     alu_res_in,
    input  logic [DATA_WIDTH-1:0]     data_mem_d_in,
    input  logic                      load_in,
    input  logic                      store_in,
    input  logic [2:0]                funct3_in,
    input  logic [R_ADRESS_WIDTH-1:0] rd_in,
    input  logic                      reg_write_en_in,
    input  logic [1:0]                write_back_mux_in,
    input  logic [DATA_WIDTH-1:0]     pc_in,
    input  logic [DATA_WIDTH-1:0]     sign_immediate_in,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [3:0]                mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      valid_out,
    output logic [DATA_WIDTH-1:0]     read_data_out,
    output logic [DATA_WIDTH-1:0]     alu_res_out,
    output logic [R_ADRESS_WIDTH-1:0] rd_out,
    output logic                      reg_write_en_out,
    output logic [1:0]                write_back_mux_out,
    output logic [DATA_WIDTH-1:0]     pc_out,
    output logic [DATA_WIDTH-1:0]     sign_immediate_out,
    output logic                      mem_fault_out
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t                      state_q, state_d;
    logic [DATA_WIDTH-1:0]       addr_q, wdata_q, pc_q, simm_q;
    logic [2:0]                  funct3_q;
    logic                        load_q, rwe_q;
    logic [R_ADRESS_WIDTH-1:0]   rd_q;
    logic [1:0]                  wbm_q;

    logic                        accept, in_mem, in_fault, capture;
    logic                        res_valid, res_from_in, res_fault;
    logic [DATA_WIDTH-1:0]       res_rdata, load_word, load_ext;
    logic [1:0]                  off_q;

    assign ready_out = (state_q == IDLE);
    assign accept    = valid_in & ready_out;
    assign in_mem    = load_in | store_in;
    assign in_fault  = in_mem & ((funct3_in == 3'b011) | (funct3_in == 3'b110) | (funct3_in == 3'b111) |
                                 ((funct3_in[1:0] == 2'b01) & alu_res_in[0]) |
                                 ((funct3_in[1:0] == 2'b10) & (alu_res_in[1:0] != 2'b00)));
    assign off_q     = addr_q[1:0];
    assign load_word = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_ext = {24'd0, load_word[7:0]};
            3'b101:  load_ext = {16'd0, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    // Bus outputs are only non-zero while a request is being presented.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        if (state_q == REQ) begin
            mem_req  = 1'b1;
            mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
            if (!load_q) begin
                mem_we = 1'b1;
                case (funct3_q[1:0])
                    2'b00: begin
                        mem_be    = 4'b0001 << off_q;
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_be    = off_q[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_be    = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        res_valid   = 1'b0;
        res_from_in = 1'b0;
        res_fault   = 1'b0;
        res_rdata   = '0;
        case (state_q)
            IDLE: if (accept) begin
                capture = 1'b1;
                if (in_mem && !in_fault) begin
                    state_d = REQ;
                end else begin
                    res_valid   = 1'b1;
                    res_from_in = 1'b1;
                    res_fault   = in_fault;
                end
            end
            REQ: if (mem_gnt) begin
                if (load_q) begin
                    state_d = WAIT_R;
                end else begin
                    state_d   = IDLE;
                    res_valid = 1'b1;
                end
            end
            WAIT_R: if (mem_rvalid) begin
                state_d   = IDLE;
                res_valid = 1'b1;
                res_rdata = load_ext;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            addr_q             <= '0;
            wdata_q            <= '0;
            pc_q               <= '0;
            simm_q             <= '0;
            funct3_q           <= 3'b000;
            load_q             <= 1'b0;
            rwe_q              <= 1'b0;
            rd_q               <= '0;
            wbm_q              <= 2'b00;
            valid_out          <= 1'b0;
            mem_fault_out      <= 1'b0;
            read_data_out      <= '0;
            alu_res_out        <= '0;
            rd_out             <= '0;
            reg_write_en_out   <= 1'b0;
            write_back_mux_out <= 2'b00;
            pc_out             <= '0;
            sign_immediate_out <= '0;
        end else begin
            state_q   <= state_d;
            valid_out <= res_valid;
            if (capture) begin
                addr_q   <= alu_res_in;
                wdata_q  <= data_mem_d_in;
                pc_q     <= pc_in;
                simm_q   <= sign_immediate_in;
                funct3_q <= funct3_in;
                load_q   <= load_in;
                rwe_q    <= reg_write_en_in;
                rd_q     <= rd_in;
                wbm_q    <= write_back_mux_in;
            end
            // Non-memory and faulting ops complete straight from the inputs.
            if (res_valid) begin
                mem_fault_out      <= res_fault;
                read_data_out      <= res_rdata;
                alu_res_out        <= res_from_in ? alu_res_in : addr_q;
                rd_out             <= res_from_in ? rd_in : rd_q;
                reg_write_en_out   <= res_from_in ? (reg_write_en_in & ~in_fault) : rwe_q;
                write_back_mux_out <= res_from_in ? write_back_mux_in : wbm_q;
                pc_out             <= res_from_in ? pc_in : pc_q;
                sign_immediate_out <= res_from_in ? sign_immediate_in : simm_q;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage; a simple bus responder and
// reference model live inline in the stimulus sequence.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0, ready_out;
    logic [31:0] alu_res_in = '0, data_mem_d_in = '0, pc_in = '0, sign_immediate_in = '0;
    logic        load_in = 1'b0, store_in = 1'b0;
    logic [2:0]  funct3_in = '0;
    logic [4:0]  rd_in = '0;
    logic        reg_write_en_in = 1'b0;
    logic [1:0]  write_back_mux_in = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        valid_out, reg_write_en_out, mem_fault_out;
    logic [31:0] read_data_out, alu_res_out, pc_out, sign_immediate_out;
    logic [4:0]  rd_out;
    logic [1:0]  write_back_mux_out;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage #(.DATA_WIDTH(32), .R_ADRESS_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
        .alu_res_in(alu_res_in), .data_mem_d_in(data_mem_d_in), .load_in(load_in),
        .store_in(store_in), .funct3_in(funct3_in), .rd_in(rd_in),
        .reg_write_en_in(reg_write_en_in), .write_back_mux_in(write_back_mux_in),
        .pc_in(pc_in), .sign_immediate_in(sign_immediate_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .valid_out(valid_out), .read_data_out(read_data_out),
        .alu_res_out(alu_res_out), .rd_out(rd_out), .reg_write_en_out(reg_write_en_out),
        .write_back_mux_out(write_back_mux_out), .pc_out(pc_out),
        .sign_immediate_out(sign_immediate_out), .mem_fault_out(mem_fault_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, ".we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, ".be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, ".valid"}, {31'd0, valid_out}, 32'd0);
        chk({tag, ".fault"}, {31'd0, mem_fault_out}, 32'd0);
        chk({tag, ".rwe"}, {31'd0, reg_write_en_out}, 32'd0);
        chk({tag, ".rdata"}, read_data_out, 32'd0);
        chk({tag, ".alu"}, alu_res_out, 32'd0);
        chk({tag, ".pc"}, pc_out, 32'd0);
    endtask

    // Issue one instruction (caller sits just after a falling edge) and play the bus.
    task automatic do_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                         input int gnt_dly, input int rv_dly);
        bit          is_mem, fault;
        int          o, sz;
        logic [31:0] w, exp_rd, exp_wd, pc, si;
        logic [3:0]  exp_be;
        logic [4:0]  rd;
        logic        rwe;
        logic [1:0]  wbm;
        rd = 5'($urandom); rwe = 1'($urandom); wbm = 2'($urandom);
        pc = $urandom; si = $urandom;
        is_mem = ld | st;
        o  = int'(a[1:0]);
        sz = int'(f3[1:0]);
        fault = is_mem && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 ||
                           (sz == 1 && (o % 2) != 0) || (sz == 2 && o != 0));
        exp_be = (sz == 0) ? 4'(1 << o) : (sz == 1) ? 4'(3 << o) : 4'hF;
        exp_wd = (sz == 0) ? d[7:0] * 32'h01010101 : (sz == 1) ? d[15:0] * 32'h00010001 : d;
        w = rdata >> (8 * o);
        case (f3)
            3'd0:    exp_rd = 32'($signed(w[7:0]));
            3'd1:    exp_rd = 32'($signed(w[15:0]));
            3'd4:    exp_rd = 32'(w[7:0]);
            3'd5:    exp_rd = 32'(w[15:0]);
            default: exp_rd = w;
        endcase

        valid_in = 1'b1; load_in = ld; store_in = st; funct3_in = f3; alu_res_in = a;
        data_mem_d_in = d; rd_in = rd; reg_write_en_in = rwe; write_back_mux_in = wbm;
        pc_in = pc; sign_immediate_in = si;
        chk({tag, ".ready_in"}, {31'd0, ready_out}, 32'd1);
        @(negedge clk);
        valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
        alu_res_in = $urandom; rd_in = 5'($urandom); pc_in = $urandom;

        if (is_mem && !fault) begin
            for (int i = 0; i < gnt_dly; i++) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
                chk({tag, ".req_wait"}, {31'd0, mem_req}, 32'd1);
                chk({tag, ".ready_busy"}, {31'd0, ready_out}, 32'd0);
                chk({tag, ".valid_early"}, {31'd0, valid_out}, 32'd0);
                @(negedge clk);
            end
            chk({tag, ".req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
            chk({tag, ".we"}, {31'd0, mem_we}, {31'd0, st});
            chk({tag, ".be"}, {28'd0, mem_be}, st ? {28'd0, exp_be} : 32'd0);
            if (st) chk({tag, ".wdata"}, mem_wdata, exp_wd);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (ld) begin
                for (int i = 0; i < rv_dly; i++) begin
                    mem_gnt = 1'b1;
                    chk({tag, ".rv_wait_valid"}, {31'd0, valid_out}, 32'd0);
                    chk({tag, ".rv_wait_req"}, {31'd0, mem_req}, 32'd0);
                    chk({tag, ".rv_wait_ready"}, {31'd0, ready_out}, 32'd0);
                    @(negedge clk);
                end
                mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
                @(negedge clk);
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
        end

        chk({tag, ".valid"}, {31'd0, valid_out}, 32'd1);
        chk({tag, ".fault"}, {31'd0, mem_fault_out}, {31'd0, fault});
        chk({tag, ".rdata"}, read_data_out, (ld && !fault) ? exp_rd : 32'd0);
        chk({tag, ".alu"}, alu_res_out, a);
        chk({tag, ".rd"}, {27'd0, rd_out}, {27'd0, rd});
        chk({tag, ".rwe"}, {31'd0, reg_write_en_out}, {31'd0, rwe & ~fault});
        chk({tag, ".wbm"}, {30'd0, write_back_mux_out}, {30'd0, wbm});
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".simm"}, sign_immediate_out, si);
        chk({tag, ".ready_done"}, {31'd0, ready_out}, 32'd1);
        if (fault) chk({tag, ".no_req"}, {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk({tag, ".pulse"}, {31'd0, valid_out}, 32'd0);
        chk({tag, ".hold"}, read_data_out, (ld && !fault) ? exp_rd : 32'd0);
    endtask

    initial begin
        logic [2:0] f3;
        int kind;

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset.ready", {31'd0, ready_out}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back non-memory ops
        valid_in = 1'b1; alu_res_in = 32'h1234; reg_write_en_in = 1'b1; funct3_in = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("add.valid", {31'd0, valid_out}, 32'd1);
            chk("add.alu", alu_res_out, 32'h1234);
            chk("add.ready", {31'd0, ready_out}, 32'd1);
            chk("add.rdata", read_data_out, 32'd0);
        end
        valid_in = 1'b0;
        @(negedge clk);
        chk("add.end", {31'd0, valid_out}, 32'd0);

        // Directed memory cases
        do_op("sb",  1'b0, 1'b1, 3'd0, 32'h103, 32'hAABBCCDD, 32'd0, 2, 0);
        do_op("lb",  1'b1, 1'b0, 3'd0, 32'h2, 32'd0, 32'h8081F0F1, 1, 4);
        do_op("lhu", 1'b1, 1'b0, 3'd5, 32'h2, 32'd0, 32'h8081F0F1, 0, 4);
        do_op("lw_mis", 1'b1, 1'b0, 3'd2, 32'h6, 32'd0, 32'd0, 0, 0);
        do_op("sh_hi", 1'b0, 1'b1, 3'd1, 32'h402, 32'h1357BEEF, 32'd0, 0, 0);
        do_op("ill", 1'b0, 1'b1, 3'd3, 32'h400, 32'h1, 32'd0, 0, 0);

        // Reset while waiting for read data
        valid_in = 1'b1; load_in = 1'b1; funct3_in = 3'd2; alu_res_in = 32'h80;
        reg_write_en_in = 1'b1; pc_in = 32'h44;
        @(negedge clk);
        valid_in = 1'b0; load_in = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rstmid.in_wait", {31'd0, ready_out}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rstmid.async");
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_idle_outputs("rstmid.late_rv");
            chk("rstmid.ready", {31'd0, ready_out}, 32'd1);
        end
        mem_rvalid = 1'b0;

        // Randomized mix against the reference model
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 2) begin
                do_op("rnd_alu", 1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 32'd0, 0, 0);
            end else if (kind < 6) begin
                case ($urandom_range(0, 6))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
                    4: f3 = 3'd5; 5: f3 = 3'd6; default: f3 = 3'd3;
                endcase
                do_op("rnd_ld", 1'b1, 1'b0, f3, $urandom, 32'd0, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd7;
                    default: f3 = 3'd0;
                endcase
                do_op("rnd_st", 1'b0, 1'b1, f3, $urandom, $urandom, 32'd0,
                      int'($urandom_range(0, 3)), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
